// File: rtl/fx2_fifo_arbiter.sv
// FX2 slave-FIFO bus arbiter: round-robin sharing of FD/FIFOADR/strobes between the
// capture stream (FIFO4), event packets (FIFO5) and the host command reader (FIFO2).
module fx2_fifo_arbiter #(
  parameter int BURST_MAX     = 64,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo2_nonempty,
  input  logic       fifo4_notfull,
  input  logic       fifo5_notfull,
  input  logic [7:0] FIFO_DATAIN,
  output logic [7:0] FIFO_DATAOUT,
  output logic       FIFO_DATAOUT_OE,
  output logic       FIFO_DATAIN_OE,
  output logic [1:0] FIFO_FIFOADR,
  output logic       FIFO_RD,
  output logic       FIFO_WR,
  output logic       FIFO_PKTEND,
  input  logic       cap_valid,
  input  logic [7:0] cap_data,
  output logic       cap_ready,
  input  logic       evt_valid,
  input  logic [7:0] evt_data,
  input  logic       evt_last,
  output logic       evt_ready,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data
);

  typedef enum logic [2:0] {IDLE, SETTLE, WR_CAP, WR_EVT, COMMIT, RD} state_t;
  typedef enum logic [1:0] {CLI_CAP, CLI_EVT, CLI_RD} client_t;

  localparam logic [7:0] BURST_LAST  = 8'(BURST_MAX);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  client_t    ptr;
  client_t    grant;
  client_t    pick;
  client_t    c1;
  client_t    c2;
  logic       found;
  logic [1:0] fifo_adr;
  logic [7:0] burst_cnt;
  logic [7:0] burst_next;
  logic [3:0] settle_cnt;
  logic       req_cap;
  logic       req_evt;
  logic       req_rd;
  logic [3:0] req;

  function automatic client_t next_client(input client_t c);
    next_client = CLI_CAP;
    case (c)
      CLI_CAP: next_client = CLI_EVT;
      CLI_EVT: next_client = CLI_RD;
      default: next_client = CLI_CAP;
    endcase
  endfunction

  function automatic logic [1:0] addr_of(input client_t c);
    addr_of = 2'b00;
    case (c)
      CLI_CAP: addr_of = 2'b10;
      CLI_EVT: addr_of = 2'b11;
      default: addr_of = 2'b00;
    endcase
  endfunction

  assign req_cap      = cap_valid & fifo4_notfull;
  assign req_evt      = evt_valid & fifo5_notfull;
  assign req_rd       = out_ready & fifo2_nonempty;
  assign req          = {1'b0, req_rd, req_evt, req_cap};
  assign burst_next   = burst_cnt + 8'd1;
  assign FIFO_FIFOADR = fifo_adr;

  // ptr names the first client to look at; it always points just past the last grant
  always_comb begin
    c1    = next_client(ptr);
    c2    = next_client(c1);
    found = 1'b1;
    pick  = ptr;
    if (req[ptr])     pick = ptr;
    else if (req[c1]) pick = c1;
    else if (req[c2]) pick = c2;
    else              found = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= CLI_CAP;
      grant      <= CLI_CAP;
      fifo_adr   <= 2'b10;
      burst_cnt  <= 8'h00;
      settle_cnt <= 4'h0;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant      <= pick;
            ptr        <= next_client(pick);
            fifo_adr   <= addr_of(pick);
            burst_cnt  <= 8'h00;
            settle_cnt <= 4'h0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            case (grant)
              CLI_CAP: state <= WR_CAP;
              CLI_EVT: state <= WR_EVT;
              default: state <= RD;
            endcase
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        WR_CAP: begin
          if (req_cap) begin
            burst_cnt <= burst_next;
            if (burst_next == BURST_LAST) state <= IDLE;
          end else begin
            state <= IDLE;
          end
        end
        // evt_last wins over burst expiry so a packet end is never left uncommitted
        WR_EVT: begin
          if (req_evt) begin
            burst_cnt <= burst_next;
            if (evt_last)                      state <= COMMIT;
            else if (burst_next == BURST_LAST) state <= IDLE;
          end else begin
            state <= IDLE;
          end
        end
        COMMIT: state <= IDLE;
        RD: begin
          if (req_rd) begin
            out_valid <= 1'b1;
            out_data  <= FIFO_DATAIN;
            burst_cnt <= burst_next;
            if (burst_next == BURST_LAST) state <= IDLE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write handshakes are combinational so the byte and WR leave on the same edge
  always_comb begin
    FIFO_DATAOUT    = 8'h00;
    FIFO_DATAOUT_OE = 1'b0;
    FIFO_DATAIN_OE  = 1'b0;
    FIFO_WR         = 1'b0;
    FIFO_RD         = 1'b0;
    FIFO_PKTEND     = 1'b0;
    cap_ready       = 1'b0;
    evt_ready       = 1'b0;
    case (state)
      WR_CAP: begin
        FIFO_DATAOUT_OE = 1'b1;
        FIFO_DATAOUT    = cap_data;
        FIFO_WR         = req_cap;
        cap_ready       = req_cap;
      end
      WR_EVT: begin
        FIFO_DATAOUT_OE = 1'b1;
        FIFO_DATAOUT    = evt_data;
        FIFO_WR         = req_evt;
        evt_ready       = req_evt;
      end
      COMMIT: begin
        FIFO_DATAOUT_OE = 1'b1;
        FIFO_PKTEND     = 1'b1;
      end
      RD: begin
        FIFO_DATAIN_OE = 1'b1;
        FIFO_RD        = req_rd;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fx2_fifo_arbiter.sv
// Scoreboard bench for fx2_fifo_arbiter: client/FX2 models feed expectation queues,
// a negedge monitor pops and compares every WR, PKTEND, RD and out_valid.
`timescale 1ns/1ps
module tb_fx2_fifo_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fifo2_nonempty;
  logic       fifo4_notfull;
  logic       fifo5_notfull;
  logic [7:0] fifo_datain;
  logic [7:0] fifo_dataout;
  logic       fifo_dataout_oe;
  logic       fifo_datain_oe;
  logic [1:0] fifo_adr;
  logic       fifo_rd;
  logic       fifo_wr;
  logic       fifo_pktend;
  logic       cap_valid;
  logic [7:0] cap_data;
  logic       cap_ready;
  logic       evt_valid;
  logic [7:0] evt_data;
  logic       evt_last;
  logic       evt_ready;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;

  logic [7:0] cap_src_q[$];
  logic [7:0] cap_exp_q[$];
  logic [8:0] evt_src_q[$];
  logic [8:0] evt_exp_q[$];
  logic [7:0] fifo2_q[$];
  logic [7:0] rd_exp_q[$];
  int         strobe_log[$];
  int         cap_cyc_q[$];
  int         exp_log[$];
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;

  fx2_fifo_arbiter #(.BURST_MAX(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .fifo2_nonempty(fifo2_nonempty), .fifo4_notfull(fifo4_notfull), .fifo5_notfull(fifo5_notfull),
    .FIFO_DATAIN(fifo_datain), .FIFO_DATAOUT(fifo_dataout),
    .FIFO_DATAOUT_OE(fifo_dataout_oe), .FIFO_DATAIN_OE(fifo_datain_oe),
    .FIFO_FIFOADR(fifo_adr), .FIFO_RD(fifo_rd), .FIFO_WR(fifo_wr), .FIFO_PKTEND(fifo_pktend),
    .cap_valid(cap_valid), .cap_data(cap_data), .cap_ready(cap_ready),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_last(evt_last), .evt_ready(evt_ready),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    tests++;
    if (actual !== required) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, actual, required, $time);
    end
  endtask

  task automatic noteFail(input string name, input string what);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got %s, required an expected entry (t=%0t)", name, what, $time);
  endtask

  function automatic int pending();
    return cap_src_q.size() + cap_exp_q.size() + evt_src_q.size() + evt_exp_q.size()
         + fifo2_q.size() + rd_exp_q.size();
  endfunction

  // kind 0 = capture byte, 1 = event byte, 2 = byte waiting in FIFO2
  task automatic applyStimulus(input int kind, input logic [7:0] d, input logic last);
    if (kind == 0) begin
      cap_src_q.push_back(d);
      cap_exp_q.push_back(d);
    end else if (kind == 1) begin
      evt_src_q.push_back({last, d});
      evt_exp_q.push_back({1'b0, d});
      if (last) evt_exp_q.push_back(9'h100);
    end else begin
      fifo2_q.push_back(d);
      rd_exp_q.push_back(d);
    end
  endtask

  task automatic checkIdle(input string name);
    checkOutput(name, 64'({fifo_adr, fifo_wr, fifo_rd, fifo_pktend, fifo_dataout_oe, fifo_datain_oe,
                           out_valid, out_data, cap_ready, evt_ready}),
                64'({2'b10, 5'b00000, 1'b0, 8'h00, 2'b00}));
  endtask

  task automatic doReset();
    reset = 1'b1;
    cap_src_q.delete(); cap_exp_q.delete(); evt_src_q.delete(); evt_exp_q.delete();
    fifo2_q.delete(); rd_exp_q.delete(); strobe_log.delete(); cap_cyc_q.delete(); exp_log.delete();
    fifo4_notfull = 1'b1;
    fifo5_notfull = 1'b1;
    out_ready     = 1'b0;
    repeat (2) @(negedge clk);
    checkIdle("reset_state");
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checkOutput({name, "_drain"}, 64'(pending()), 64'd0);
  endtask

  task automatic checkLog(input string name);
    int bad = -1;
    tests++;
    if (strobe_log.size() != exp_log.size()) bad = 0;
    else foreach (exp_log[i]) if (bad < 0 && strobe_log[i] != exp_log[i]) bad = i;
    if (bad >= 0) begin
      fails++;
      $display("[TB] FAIL %s: got %0d strobes (entry %0d = %0d), required %0d strobes (entry = %0d)",
               name, strobe_log.size(), bad, (bad < strobe_log.size()) ? strobe_log[bad] : -1,
               exp_log.size(), (bad < exp_log.size()) ? exp_log[bad] : -1);
    end
  endtask

  initial begin : cap_driver
    logic acc;
    cap_valid = 1'b0;
    cap_data  = 8'h00;
    forever begin
      @(negedge clk); acc = cap_ready;
      @(posedge clk); #1;
      if (acc && cap_src_q.size() > 0) void'(cap_src_q.pop_front());
      cap_valid = (cap_src_q.size() > 0);
      cap_data  = cap_valid ? cap_src_q[0] : 8'h00;
    end
  end

  initial begin : evt_driver
    logic acc;
    evt_valid = 1'b0;
    evt_data  = 8'h00;
    evt_last  = 1'b0;
    forever begin
      @(negedge clk); acc = evt_ready;
      @(posedge clk); #1;
      if (acc && evt_src_q.size() > 0) void'(evt_src_q.pop_front());
      evt_valid = (evt_src_q.size() > 0);
      evt_data  = evt_valid ? evt_src_q[0][7:0] : 8'h00;
      evt_last  = evt_valid ? evt_src_q[0][8] : 1'b0;
    end
  end

  initial begin : fifo2_model
    logic acc;
    fifo2_nonempty = 1'b0;
    fifo_datain    = 8'h00;
    forever begin
      @(negedge clk); acc = fifo_rd;
      @(posedge clk); #1;
      if (acc && fifo2_q.size() > 0) void'(fifo2_q.pop_front());
      fifo2_nonempty = (fifo2_q.size() > 0);
      fifo_datain    = fifo2_nonempty ? fifo2_q[0] : 8'h00;
    end
  end

  // Strobe codes in strobe_log: 2 = FIFO4 write, 3 = FIFO5 write, 4 = PKTEND, 5 = FIFO2 read
  initial begin : monitor
    logic prev_out_oe, prev_in_oe, prev_rd;
    prev_out_oe = 1'b0; prev_in_oe = 1'b0; prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prev_out_oe = 1'b0; prev_in_oe = 1'b0; prev_rd = 1'b0;
      end else begin
        tests++;
        assert (!(fifo_dataout_oe && fifo_datain_oe)) else begin
          fails++;
          $display("[TB] FAIL oe_excl: got out_oe=%0b in_oe=%0b, required not both 1", fifo_dataout_oe, fifo_datain_oe);
        end
        if ((fifo_dataout_oe && !prev_out_oe) || (fifo_datain_oe && !prev_in_oe))
          checkOutput("oe_turnaround", 64'({prev_out_oe, prev_in_oe}), 64'd0);
        if (fifo_wr) begin
          checkOutput("wr_bus", 64'({fifo_dataout_oe, fifo_rd}), 64'b10);
          if (fifo_adr == 2'b10) begin
            strobe_log.push_back(2);
            cap_cyc_q.push_back(cyc);
            if (cap_exp_q.size() == 0) noteFail("cap_wr", "unexpected write");
            else checkOutput("cap_wr", 64'(fifo_dataout), 64'(cap_exp_q.pop_front()));
          end else if (fifo_adr == 2'b11) begin
            strobe_log.push_back(3);
            if (evt_exp_q.size() == 0) noteFail("evt_wr", "unexpected write");
            else checkOutput("evt_wr", 64'({1'b0, fifo_dataout}), 64'(evt_exp_q.pop_front()));
          end else begin
            strobe_log.push_back(9);
            noteFail("wr_adr", "write to FIFO2 address");
          end
        end
        if (fifo_pktend) begin
          strobe_log.push_back(4);
          checkOutput("pktend_bus", 64'({fifo_wr, fifo_dataout_oe, fifo_adr}), 64'b0111);
          if (evt_exp_q.size() == 0) noteFail("pktend_order", "unexpected PKTEND");
          else checkOutput("pktend_order", 64'(evt_exp_q.pop_front()), 64'h100);
        end
        if (fifo_rd) begin
          strobe_log.push_back(5);
          checkOutput("rd_bus", 64'({fifo_datain_oe, fifo_dataout_oe, fifo_adr}), 64'b1000);
        end
        if (out_valid || prev_rd) checkOutput("rd_latency", 64'(out_valid), 64'(prev_rd));
        if (out_valid) begin
          if (rd_exp_q.size() == 0) noteFail("out_data", "unexpected out_valid");
          else checkOutput("out_data", 64'(out_data), 64'(rd_exp_q.pop_front()));
        end
        prev_out_oe = fifo_dataout_oe;
        prev_in_oe  = fifo_datain_oe;
        prev_rd     = fifo_rd;
      end
    end
  end

  initial begin : watchdog
    #200000;
    fails++;
    $display("[TB] FAIL watchdog: got no finish by %0t, required completion", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : main
    int t_req, t_wr, n, bad;

    // Capture alone: 1 IDLE + 1 SETTLE + 4 WR, repeating
    doReset();
    for (int i = 0; i < 12; i++) applyStimulus(0, 8'(8'hA0 + i), 1'b0);
    t_req = -1; t_wr = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cap_valid && t_req < 0) t_req = k;
      if (fifo_wr) begin t_wr = k; break; end
    end
    checkOutput("cap_first_strobe", 64'(t_wr - t_req), 64'd2);
    waitDrain("cap_alone", 200);
    bad = (cap_cyc_q.size() == 12) ? -1 : 99;
    if (bad < 0) foreach (cap_cyc_q[k])
      if (bad < 0 && cap_cyc_q[k] - cap_cyc_q[0] != (k / 4) * 6 + k % 4) bad = k;
    checkOutput("cap_burst_timing", 64'(bad), 64'(-1));
    for (int i = 0; i < 12; i++) exp_log.push_back(2);
    checkLog("cap_alone_log");

    // Event packet arriving during a capture burst
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(0, 8'(8'hB0 + i), 1'b0);
    n = 0;
    while (strobe_log.size() == 0 && n < 50) begin @(negedge clk); n++; end
    applyStimulus(1, 8'hE1, 1'b0);
    applyStimulus(1, 8'hE2, 1'b0);
    applyStimulus(1, 8'hE3, 1'b1);
    waitDrain("evt_packet", 200);
    exp_log = '{2, 2, 2, 2, 3, 3, 3, 4, 2, 2, 2, 2};
    checkLog("evt_packet_log");

    // FIFO2 read of 5 bytes, split by the burst limit of 4
    doReset();
    out_ready = 1'b1;
    applyStimulus(2, 8'h11, 1'b0);
    applyStimulus(2, 8'h22, 1'b0);
    applyStimulus(2, 8'h33, 1'b0);
    applyStimulus(2, 8'h44, 1'b0);
    applyStimulus(2, 8'h55, 1'b0);
    waitDrain("read5", 200);
    checkOutput("read_release", 64'(fifo_datain_oe), 64'd0);
    exp_log = '{5, 5, 5, 5, 5};
    checkLog("read5_log");

    // Direction change from WR_CAP to RD
    doReset();
    out_ready = 1'b1;
    applyStimulus(0, 8'hC1, 1'b0);
    applyStimulus(0, 8'hC2, 1'b0);
    applyStimulus(2, 8'hD1, 1'b0);
    applyStimulus(2, 8'hD2, 1'b0);
    waitDrain("turnaround", 200);
    exp_log = '{2, 2, 5, 5};
    checkLog("turnaround_log");

    // FIFO4 full for 3 cycles in the middle of a burst
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(0, 8'(8'h50 + i), 1'b0);
    n = 0;
    while (cap_cyc_q.size() < 2 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 fifo4_notfull = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall_quiet", 64'({fifo_wr, cap_ready}), 64'b00);
    end
    @(posedge clk); #1 fifo4_notfull = 1'b1;
    waitDrain("stall", 200);
    for (int i = 0; i < 8; i++) exp_log.push_back(2);
    checkLog("stall_log");

    // Reset during COMMIT
    doReset();
    applyStimulus(1, 8'hE5, 1'b1);
    n = 0;
    while (!fifo_pktend && n < 50) begin @(negedge clk); n++; end
    checkOutput("commit_seen", 64'(fifo_pktend), 64'd1);
    #2 reset = 1'b1;
    #1 checkOutput("async_reset", 64'({fifo_pktend, fifo_wr, fifo_dataout_oe, fifo_datain_oe, fifo_adr}),
                   64'b000010);
    checkOutput("commit_reset_drain", 64'(pending()), 64'd0);
    doReset();
    repeat (2) @(negedge clk);
    checkIdle("after_reset_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
